// File: rtl/usxgmii_rx_rate_adapt.sv
// Receive-side USXGMII rate adaptation: collapses each R-fold replicated PCS word into one
// strobed word, aligns the sampling phase to START and flags replicas that disagree.
module usxgmii_rx_rate_adapt #(
  parameter int unsigned P_ERR_CNT_WIDTH  = 16,
  parameter logic [7:0]  P_START_CHAR     = 8'hFB,
  parameter bit          P_CHECK_REPLICAS = 1'b1
) (
  input  logic                       i_usxgmii_clock,
  input  logic                       i_usxgmii_reset,
  input  logic [2:0]                 i_speed,
  input  logic                       i_pcs_valid,
  input  logic [3:0]                 i_pcs_control,
  input  logic [31:0]                i_pcs_data,
  output logic                       o_usxgmii_valid,
  output logic [3:0]                 o_usxgmii_control,
  output logic [31:0]                o_usxgmii_data,
  output logic                       o_locked,
  output logic                       o_rep_error,
  output logic [P_ERR_CNT_WIDTH-1:0] o_rep_error_count,
  output logic                       o_speed_error
);

  // Stream protocol: no backpressure on either side. i_pcs_valid qualifies the input word in
  // the cycle it is high; o_usxgmii_valid is a one-cycle strobe the consumer must take at once,
  // while o_usxgmii_control/o_usxgmii_data hold the last strobed word between strobes.

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  localparam logic [3:0]  IDLE_CTL  = 4'hF;
  localparam logic [31:0] IDLE_DATA = 32'h07070707;

  state_t                     state_q, state_d;
  logic [2:0]                 speed_q;
  logic [9:0]                 cnt_q, cnt_d;
  logic                       prev_hit_q, prev_hit_d;
  logic                       valid_q, valid_d;
  logic [3:0]                 ctl_q, ctl_d;
  logic [31:0]                data_q, data_d;
  logic                       rep_err_q, rep_err_d;
  logic [P_ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

  logic       speed_change;
  logic       speed_bad;
  logic       start_hit;
  logic       start_edge;
  logic       replica_bad;
  logic [9:0] last_phase;
  logic [9:0] cnt_next;

  // Last phase index of a replication group (R-1) for the registered speed.
  always_comb begin
    last_phase = 10'd0;
    case (speed_q)
      3'd1:    last_phase = 10'd1;
      3'd2:    last_phase = 10'd3;
      3'd3:    last_phase = 10'd9;
      3'd4:    last_phase = 10'd99;
      3'd5:    last_phase = 10'd999;
      default: last_phase = 10'd0;
    endcase
  end

  assign speed_change = (i_speed != speed_q);
  assign speed_bad    = speed_q[2] & speed_q[1];
  assign start_hit    = i_pcs_control[0] && (i_pcs_data[7:0] == P_START_CHAR);
  assign start_edge   = start_hit && !prev_hit_q;
  assign cnt_next     = (cnt_q == last_phase) ? 10'd0 : cnt_q + 10'd1;
  // The output register doubles as the sample: in LOCKED it always holds the last word emitted.
  assign replica_bad  = ({i_pcs_control, i_pcs_data} != {ctl_q, data_q});

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    prev_hit_d = prev_hit_q;
    valid_d    = 1'b0;
    ctl_d      = ctl_q;
    data_d     = data_q;
    rep_err_d  = 1'b0;
    err_cnt_d  = err_cnt_q;

    if (speed_change) begin
      // The word arriving with a speed change is dropped outright.
      cnt_d   = 10'd0;
      state_d = (i_speed == 3'd0) ? ST_LOCKED : ST_HUNT;
    end else if (i_pcs_valid) begin
      prev_hit_d = start_hit;
      if (speed_bad) begin
        state_d = ST_HUNT;
      end else if (speed_q == 3'd0) begin
        state_d = ST_LOCKED;
        valid_d = 1'b1;
        ctl_d   = i_pcs_control;
        data_d  = i_pcs_data;
      end else if (start_edge) begin
        // Realign (or acquire) on START; it wins over any replica check.
        state_d = ST_LOCKED;
        cnt_d   = 10'd1;
        valid_d = 1'b1;
        ctl_d   = i_pcs_control;
        data_d  = i_pcs_data;
      end else begin
        cnt_d = cnt_next;
        if (cnt_q == 10'd0) begin
          valid_d = 1'b1;
          if (state_q == ST_LOCKED) begin
            ctl_d  = i_pcs_control;
            data_d = i_pcs_data;
          end else begin
            ctl_d  = IDLE_CTL;
            data_d = IDLE_DATA;
          end
        end else if (P_CHECK_REPLICAS && (state_q == ST_LOCKED) && replica_bad) begin
          rep_err_d = 1'b1;
          state_d   = ST_HUNT;
          if (err_cnt_q != {P_ERR_CNT_WIDTH{1'b1}}) begin
            err_cnt_d = err_cnt_q + P_ERR_CNT_WIDTH'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge i_usxgmii_clock or posedge i_usxgmii_reset) begin
    if (i_usxgmii_reset) begin
      state_q    <= ST_HUNT;
      speed_q    <= 3'd0;
      cnt_q      <= 10'd0;
      prev_hit_q <= 1'b0;
      valid_q    <= 1'b0;
      ctl_q      <= IDLE_CTL;
      data_q     <= IDLE_DATA;
      rep_err_q  <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      speed_q    <= i_speed;
      cnt_q      <= cnt_d;
      prev_hit_q <= prev_hit_d;
      valid_q    <= valid_d;
      ctl_q      <= ctl_d;
      data_q     <= data_d;
      rep_err_q  <= rep_err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign o_usxgmii_valid   = valid_q;
  assign o_usxgmii_control = ctl_q;
  assign o_usxgmii_data    = data_q;
  assign o_locked          = (state_q == ST_LOCKED);
  assign o_rep_error       = rep_err_q;
  assign o_rep_error_count = err_cnt_q;
  assign o_speed_error     = speed_bad;

endmodule
